uart_transmitter: RTL

//  Serialises one byte per request onto an 8N1 UART line (idle high, LSB first).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_counter.sv | 33 +++
 rtl/uart_transmitter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, default bit period.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // One frame carries a single byte, LSB first
  localparam int UART_DATA_BITS = 8;

  // Default i_clk cycles per UART bit; RX and TX both take their default from here
  localparam int UART_CLKS_PER_BIT = 127;

  // Transmit FSM states; PARITY is only reached when the parity build option is on
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
// Latency: o_bit_end is a decode of the count register, valid in the same cycle.
// Backpressure: none; i_clear holds the count at zero while the owner is idle.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  // Count within a bit period; wrap at the last count so consecutive bits start at 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_bit_end = (cnt_q == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per accepted request, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Latency: start bit on o_tx the cycle after accept; o_done pulses 10*CLKS_PER_BIT+1 cycles after accept (11*.. with parity).
// Backpressure: o_ready=1 only in IDLE; i_valid while busy is dropped, nothing is queued.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_done
);

  uart_state_t               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      baud_clear;
  logic                      bit_end;

  // The bit timer only runs while a bit is on the line
  assign baud_clear = (state_q == IDLE) || (state_q == DONE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (baud_clear),
    .o_bit_end(bit_end)
  );

  // State, data and line registers; o_tx/o_done come straight from flops
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  // Next state, then the line level that the next state puts on o_tx
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = 1'b1;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d   = START;
          shift_d   = i_data;
          bit_idx_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registering the decode of state_d keeps o_tx aligned with the state it belongs to
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
    done_d = (state_d == DONE);
  end

  assign o_ready = (state_q == IDLE);
  assign o_tx    = tx_q;
  assign o_done  = done_q;

endmodule
